// File: rtl/im_addr_responder_if.sv
// Item-memory address responder bus: address stream, SRAM read port, vector stream.
// Optional frame-last signalling is compiled in with IM_RD_LAST_EN.
interface im_addr_responder_if #(
  parameter int unsigned HVDimension = 512,
  parameter int unsigned ImAddrWidth = 10
);
  logic [ImAddrWidth-1:0] addr_i;
  logic                   addr_valid_i;
  logic                   addr_ready_o;
  logic                   mem_req_o;
  logic [ImAddrWidth-1:0] mem_addr_o;
  logic [HVDimension-1:0] mem_rdata_i;
  logic [HVDimension-1:0] im_o;
  logic                   im_valid_o;
  logic                   im_ready_i;
`ifdef IM_RD_LAST_EN
  logic [31:0]            max_count_i;
  logic                   im_last_o;
`endif

  modport slave (
    input  addr_i,
    input  addr_valid_i,
    output addr_ready_o,
    output mem_req_o,
    output mem_addr_o,
    input  mem_rdata_i,
    output im_o,
    output im_valid_o,
`ifdef IM_RD_LAST_EN
    input  max_count_i,
    output im_last_o,
`endif
    input  im_ready_i
  );

  modport master (
    output addr_i,
    output addr_valid_i,
    input  addr_ready_o,
    input  mem_req_o,
    input  mem_addr_o,
    output mem_rdata_i,
    input  im_o,
    input  im_valid_o,
`ifdef IM_RD_LAST_EN
    output max_count_i,
    input  im_last_o,
`endif
    output im_ready_i
  );
endinterface

// File: rtl/im_addr_responder.sv
// Item-memory address responder: SRAM read issue plus output FIFO.
// Define IM_RD_LAST_EN to add the per-frame beat counter and im_last_o.
module im_addr_responder #(
  parameter int unsigned HVDimension = 512,
  parameter int unsigned NumTotIm    = 1024,
  parameter int unsigned ImAddrWidth = $clog2(NumTotIm),
  parameter int unsigned FifoDepth   = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  im_addr_responder_if.slave bus
);

  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned PtrW = $clog2(FifoDepth);

  typedef logic [ImAddrWidth-1:0] addr_t;
  typedef logic [HVDimension-1:0] hv_t;
  typedef logic [CntW-1:0]        cnt_t;
  typedef logic [PtrW-1:0]        ptr_t;
  typedef logic [CntW:0]          lvl_t;

  localparam lvl_t DepthLvl = lvl_t'(FifoDepth);
  localparam cnt_t FullOcc  = cnt_t'(FifoDepth);
  localparam ptr_t LastPtr  = ptr_t'(FifoDepth - 1);

  cnt_t  occ_q, occ_d;
  logic  inflight_q, inflight_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  ptr_t  wr_ptr_q, wr_ptr_d;
  addr_t last_addr_q, last_addr_d;
  hv_t   fifo_q [FifoDepth];

  logic flush;
  lvl_t level;
  logic accept;
  logic push;
  logic pop;
  logic im_valid;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LastPtr) ? '0 : p + ptr_t'(1);
  endfunction

  assign flush = rst_i | clr_i;

  // In-flight read holds a reserved slot so a stalled FIFO never drops it
  assign level = lvl_t'(occ_q) + lvl_t'(inflight_q);

  assign bus.addr_ready_o = !flush && (level < DepthLvl);
  assign accept           = bus.addr_valid_i & bus.addr_ready_o;

  assign bus.mem_req_o  = accept;
  assign bus.mem_addr_o = rst_i  ? '0 :
                          accept ? bus.addr_i : last_addr_q;

  assign im_valid       = (occ_q != '0) && !rst_i;
  assign bus.im_valid_o = im_valid;
  assign bus.im_o       = im_valid ? fifo_q[rd_ptr_q] : '0;

  assign push = inflight_q & !flush;
  assign pop  = im_valid & bus.im_ready_i & !flush;

  always_comb begin
    occ_d       = occ_q;
    inflight_d  = accept;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    last_addr_d = accept ? bus.addr_i : last_addr_q;
    if (flush) begin
      occ_d      = '0;
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + cnt_t'(1);
        2'b01:   occ_d = occ_q - cnt_t'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      last_addr_q <= '0;
    end else begin
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      last_addr_q <= last_addr_d;
    end
  end

  // Storage is never reset; im_o is masked whenever the FIFO is empty
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= bus.mem_rdata_i;
    end
  end

`ifdef IM_RD_LAST_EN
  addr_t beat_q, beat_d;
  addr_t beat_lim;
  logic  is_last;
  logic  unused_max_count;

  // A zero frame length wraps to all-ones, i.e. the full address range
  assign beat_lim = bus.max_count_i[ImAddrWidth-1:0] - addr_t'(1);
  assign is_last  = (beat_q == beat_lim);

  assign bus.im_last_o = im_valid & is_last;

  assign unused_max_count = ^bus.max_count_i;

  always_comb begin
    beat_d = beat_q;
    if (clr_i) begin
      beat_d = '0;
    end else if (pop) begin
      beat_d = is_last ? '0 : beat_q + addr_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end
`endif

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (flush)
    !(push && !pop && (occ_q == FullOcc))
  );

  a_no_underflow: assert property (
    @(posedge clk_i) disable iff (flush)
    !(pop && (occ_q == '0))
  );

endmodule

// File: tb/tb_im_addr_responder.sv
// Randomized bench for im_addr_responder against a queue-based model.
// Frame-last checks are compiled in with IM_RD_LAST_EN.
module tb_im_addr_responder;

  localparam int HV = 512;
  localparam int AW = 10;
  localparam int D  = 3;
  localparam int FRAME = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic clr_i = 1'b0;

  always #5 clk_i = ~clk_i;

  im_addr_responder_if #(.HVDimension(HV), .ImAddrWidth(AW)) bus ();

  im_addr_responder #(
    .HVDimension(HV),
    .NumTotIm   (1024),
    .FifoDepth  (D)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(clr_i),
    .bus  (bus)
  );

  function automatic logic [HV-1:0] word(input int a);
    logic [HV-1:0] w;
    for (int k = 0; k < HV / 32; k++) begin
      w[k*32 +: 32] = (32'(a) + 32'd1) * 32'h9E37_79B1 ^ (32'(k) * 32'h0101_0101);
    end
    return w;
  endfunction

  logic [HV-1:0] junk;
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  always @(posedge clk_i) begin
    rd_pend <= bus.mem_req_o;
    rd_addr <= bus.mem_addr_o;
  end

  assign bus.mem_rdata_i = rd_pend ? word(int'(rd_addr)) : junk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [HV-1:0] got,
                     input logic [HV-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int q[$];
  bit inf_m   = 1'b0;
  int inf_a   = 0;
  int last_m  = 0;
  int pops_m  = 0;

  task automatic step(input bit rst, input bit clr, input bit av,
                      input int a, input bit ir,
                      output bit acc, output bit dut_acc);
    bit exp_rdy, exp_v, pop;
    int exp_addr;
    @(negedge clk_i);
    rst_i            = rst;
    clr_i            = clr;
    bus.addr_valid_i = av;
    bus.addr_i       = AW'(a);
    bus.im_ready_i   = ir;
    junk             = {16{$urandom}};
    #1;
    exp_rdy  = !rst && !clr && (q.size() + int'(inf_m) < D);
    exp_v    = !rst && (q.size() > 0);
    acc      = av && exp_rdy;
    pop      = exp_v && ir;
    exp_addr = rst ? 0 : (acc ? a : last_m);
    dut_acc  = av && bus.addr_ready_o;
    chk("addr_ready", HV'(bus.addr_ready_o), HV'(exp_rdy));
    chk("mem_req", HV'(bus.mem_req_o), HV'(acc));
    chk("mem_addr", HV'(bus.mem_addr_o), HV'(exp_addr));
    chk("im_valid", HV'(bus.im_valid_o), HV'(exp_v));
    chk("im_data", bus.im_o, exp_v ? word(q[0]) : '0);
`ifdef IM_RD_LAST_EN
    chk("im_last", HV'(bus.im_last_o),
        HV'(exp_v && ((pops_m % FRAME) == FRAME - 1)));
`endif
    if (rst || clr) begin
      q.delete();
      inf_m  = 1'b0;
      pops_m = 0;
      if (rst) last_m = 0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        pops_m++;
      end
      if (inf_m) q.push_back(inf_a);
      inf_m = acc;
      inf_a = a;
      if (acc) last_m = a;
    end
  endtask

  task automatic idle(input int n, input bit ir);
    bit a0, d0;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, ir, a0, d0);
  endtask

  initial begin
    bit acc, dacc;
    int next_a, cnt;
    bus.addr_valid_i = 1'b0;
    bus.addr_i       = '0;
    bus.im_ready_i   = 1'b0;
    junk             = '0;
`ifdef IM_RD_LAST_EN
    bus.max_count_i  = 32'(FRAME);
`endif

    step(1, 0, 1, 7, 1, acc, dacc);
    step(1, 0, 0, 0, 0, acc, dacc);

    // single read
    step(0, 0, 1, 5, 0, acc, dacc);
    idle(3, 0);
    idle(2, 1);

    // streaming
    next_a = 0;
    for (int i = 0; i < 40 && next_a < 16; i++) begin
      step(0, 0, 1, next_a, 1, acc, dacc);
      if (acc) next_a++;
    end
    chk("stream_count", HV'(next_a), HV'(16));
    idle(4, 1);

    // back-pressure
    cnt = 0;
    next_a = 100;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, next_a, 0, acc, dacc);
      if (dacc) cnt++;
      if (acc) next_a++;
    end
    chk("bp_accepts", HV'(cnt), HV'(3));
    for (int i = 0; i < 40 && next_a < 110; i++) begin
      step(0, 0, 1, next_a, 1, acc, dacc);
      if (acc) next_a++;
    end
    idle(4, 1);

    // flush with occ=2 and one read in flight
    for (int i = 0; i < 3; i++) step(0, 0, 1, 200 + i, 0, acc, dacc);
    step(0, 1, 1, 250, 0, acc, dacc);
    step(0, 0, 1, 9, 0, acc, dacc);
    idle(3, 0);
    idle(2, 1);

    // reset while full
    for (int i = 0; i < 5; i++) step(0, 0, 1, 300 + i, 0, acc, dacc);
    step(1, 0, 1, 400, 1, acc, dacc);
    step(0, 0, 1, 3, 0, acc, dacc);
    idle(3, 1);

`ifdef IM_RD_LAST_EN
    // frame counting with a restart after two pops
    for (int i = 0; i < 8; i++) step(0, 0, 1, 500 + i, 1, acc, dacc);
    idle(4, 1);
    step(0, 0, 1, 600, 1, acc, dacc);
    step(0, 0, 1, 601, 1, acc, dacc);
    idle(3, 1);
    step(0, 1, 0, 0, 1, acc, dacc);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 700 + i, 1, acc, dacc);
    idle(4, 1);
`endif

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(99) < 1), ($urandom_range(99) < 3),
           ($urandom_range(99) < 70), int'($urandom_range(1023)),
           ($urandom_range(99) < 60), acc, dacc);
    end
    idle(6, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
